// File: rtl/ioctl_sdram_loader.sv
// Packs the HPS ioctl byte-download stream into 16-bit words with byte enables,
// buffers them in a small FIFO and writes them to a word-addressed memory port.
module ioctl_sdram_loader #(
  parameter int INDEX     = 0,
  parameter int FIFO_BITS = 3,
  parameter int MEM_AW    = 22
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  output logic              load_done,
  output logic [24:0]       load_size,
  output logic              overflow,
  output logic              range_err
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int CW    = FIFO_BITS + 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  state_t state;

  logic [MEM_AW-1:0]    fifo_addr [DEPTH];
  logic [15:0]          fifo_data [DEPTH];
  logic [1:0]           fifo_be   [DEPTH];
  logic [FIFO_BITS-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]        cnt, cnt_nxt;

  logic              hold_vld, hold_odd;
  logic [MEM_AW-1:0] hold_addr;
  logic [7:0]        hold_data;

  logic              active, in_range, byte_acc, range_hit, pair;
  logic [MEM_AW-1:0] byte_addr;
  logic              byte_odd;
  logic [24:0]       addr_p1;
  logic              push_req, push, pop, full, empty;
  logic [MEM_AW-1:0] push_addr;
  logic [15:0]       push_data;
  logic [1:0]        push_be;
  logic              flush_done, flush_nxt, wait_nxt;

  assign active    = ioctl_download && (ioctl_index == 8'(INDEX));
  assign in_range  = (ioctl_addr >> (MEM_AW + 1)) == '0;
  assign byte_acc  = (state == LOAD) && active && ioctl_wr && in_range;
  assign range_hit = (state == LOAD) && active && ioctl_wr && !in_range;
  assign byte_addr = ioctl_addr[MEM_AW:1];
  assign byte_odd  = ioctl_addr[0];
  assign addr_p1   = ioctl_addr + 25'd1;
  assign pair      = hold_vld && (hold_addr == byte_addr) && (hold_odd != byte_odd);

  // Push either the lone held byte or the hold merged with the incoming byte.
  always_comb begin
    push_req  = 1'b0;
    push_addr = hold_addr;
    push_data = hold_odd ? {hold_data, 8'h00} : {8'h00, hold_data};
    push_be   = hold_odd ? 2'b10 : 2'b01;
    if (byte_acc && hold_vld) begin
      push_req = 1'b1;
      if (pair) begin
        push_data = byte_odd ? {ioctl_dout, hold_data} : {hold_data, ioctl_dout};
        push_be   = 2'b11;
      end
    end else if ((state == FLUSH) && hold_vld) begin
      push_req = 1'b1;
    end
  end

  assign full       = (cnt == CW'(DEPTH));
  assign empty      = (cnt == '0);
  assign push       = push_req && !full;
  assign pop        = !mem_req && !empty;
  assign cnt_nxt    = cnt + CW'(push) - CW'(pop);
  assign flush_done = (state == FLUSH) && !hold_vld && empty && !mem_req;
  assign flush_nxt  = ((state == LOAD) && !active) || ((state == FLUSH) && !flush_done);
  assign wait_nxt   = (cnt_nxt >= CW'(DEPTH - 2)) || flush_nxt;

  // Storage: FIFO entries and hold payload carry no reset.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= push_data;
      fifo_be[wr_ptr]   <= push_be;
    end
    if (byte_acc && !pair) begin
      hold_addr <= byte_addr;
      hold_data <= ioctl_dout;
      hold_odd  <= byte_odd;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hold_vld   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_be     <= '0;
      load_done  <= 1'b0;
      load_size  <= '0;
      overflow   <= 1'b0;
      range_err  <= 1'b0;
      ioctl_wait <= 1'b0;
    end else begin
      load_done  <= 1'b0;
      ioctl_wait <= wait_nxt;
      cnt        <= cnt_nxt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (push_req && full)
        overflow <= 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        mem_req  <= 1'b1;
        mem_addr <= fifo_addr[rd_ptr];
        mem_din  <= fifo_data[rd_ptr];
        mem_be   <= fifo_be[rd_ptr];
      end else if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
      end
      if (range_hit)
        range_err <= 1'b1;
      if (byte_acc) begin
        hold_vld <= !pair;
        if (addr_p1 > load_size)
          load_size <= addr_p1;
      end
      case (state)
        IDLE: if (active) begin
          state     <= LOAD;
          overflow  <= 1'b0;
          range_err <= 1'b0;
          load_size <= '0;
          hold_vld  <= 1'b0;
        end
        LOAD: if (!active) state <= FLUSH;
        FLUSH: begin
          hold_vld <= 1'b0;
          if (flush_done) begin
            state     <= DONE;
            load_done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench for ioctl_sdram_loader: packing, tail flush, backpressure,
// overflow/range flags, index filtering and asynchronous reset.
module tb_ioctl_sdram_loader;

  localparam int IDX = 0;
  localparam int AW  = 22;

  logic          clk_sys;
  logic          reset_n;
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [1:0]    mem_be;
  logic          mem_ack;
  logic          load_done;
  logic [24:0]   load_size;
  logic          overflow;
  logic          range_err;

  ioctl_sdram_loader #(.INDEX(IDX), .FIFO_BITS(3), .MEM_AW(AW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
    .mem_ack(mem_ack),
    .load_done(load_done), .load_size(load_size),
    .overflow(overflow), .range_err(range_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int wr_at_done = 0;
  logic ack_en = 1'b0;
  logic [AW-1:0] log_addr [256];
  logic [15:0]   log_din  [256];
  logic [1:0]    log_be   [256];

  // Memory responder: acks one cycle after each request and logs the write.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (mem_req && ack_en && !mem_ack) begin
        log_addr[wr_cnt] = mem_addr;
        log_din[wr_cnt]  = mem_din;
        log_be[wr_cnt]   = mem_be;
        wr_cnt++;
        mem_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
      end
      if (load_done) begin
        done_cnt++;
        wr_at_done = wr_cnt;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index = idx; ioctl_download = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic wait_done(input int base, input string tag);
    int k = 0;
    while (done_cnt == base && k < 300) begin
      @(negedge clk_sys);
      k++;
    end
    chk(tag, 32'(done_cnt > base), 32'd1);
    repeat (3) @(negedge clk_sys);
    chk({tag, "_once"}, 32'(done_cnt), 32'(base + 1));
  endtask

  int wb, db, sent, first_wait;

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_flags", {30'd0, overflow, range_err}, 32'd0);
    chk("rst_size", 32'(load_size), 32'd0);
    chk("rst_mem_bus", {mem_be, mem_din}, 32'd0);
    reset_n = 1'b1;

    // Contiguous six-byte load
    ack_en = 1'b1; wb = wr_cnt; db = done_cnt;
    start_dl(8'(IDX));
    chk("load_wait_idle", 32'(ioctl_wait), 32'd0);
    for (int i = 0; i < 6; i++) send_byte(25'(i), 8'(8'h11 + i));
    repeat (4) @(negedge clk_sys);
    ioctl_download = 1'b0;
    wait_done(db, "c_done");
    chk("c_wr_cnt", 32'(wr_cnt - wb), 32'd3);
    chk("c_w0", {8'd0, log_addr[wb]}, 32'h0);
    chk("c_d0", {14'd0, log_be[wb], log_din[wb]}, 32'h31211);
    chk("c_w1", {8'd0, log_addr[wb+1]}, 32'h1);
    chk("c_d1", {14'd0, log_be[wb+1], log_din[wb+1]}, 32'h31413);
    chk("c_w2", {8'd0, log_addr[wb+2]}, 32'h2);
    chk("c_d2", {14'd0, log_be[wb+2], log_din[wb+2]}, 32'h31615);
    chk("c_size", 32'(load_size), 32'd6);
    chk("c_flags", {30'd0, overflow, range_err}, 32'd0);

    // Odd-length tail flushed as a half word before completion
    wb = wr_cnt; db = done_cnt;
    start_dl(8'(IDX));
    send_byte(25'd0, 8'hAA);
    send_byte(25'd1, 8'hBB);
    send_byte(25'd2, 8'hCC);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("t_wait_flush", 32'(ioctl_wait), 32'd1);
    wait_done(db, "t_done");
    chk("t_wr_cnt", 32'(wr_cnt - wb), 32'd2);
    chk("t_d0", {14'd0, log_be[wb], log_din[wb]}, 32'h3BBAA);
    chk("t_w1", {8'd0, log_addr[wb+1]}, 32'h1);
    chk("t_d1", {14'd0, log_be[wb+1], log_din[wb+1]}, 32'h100CC);
    chk("t_before_done", 32'(wr_at_done - wb), 32'd2);
    chk("t_size", 32'(load_size), 32'd3);

    // Backpressure: ack withheld for 40 cycles, source honours ioctl_wait
    ack_en = 1'b0; wb = wr_cnt; db = done_cnt;
    start_dl(8'(IDX));
    sent = 0; first_wait = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_sys);
      if (c == 40) ack_en = 1'b1;
      if (ioctl_wait && first_wait < 0) first_wait = sent;
      if (!ioctl_wait && sent < 16) begin
        ioctl_wr = 1'b1; ioctl_addr = 25'(sent); ioctl_dout = 8'(sent + 32);
        sent++;
      end else begin
        ioctl_wr = 1'b0;
      end
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    wait_done(db, "b_done");
    chk("b_wait_point", 32'(first_wait), 32'd14);
    chk("b_wr_cnt", 32'(wr_cnt - wb), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("b_addr", {8'd0, log_addr[wb+i]}, 32'(i));
      chk("b_data", {14'd0, log_be[wb+i], log_din[wb+i]},
          {14'd0, 2'b11, 8'(2*i + 33), 8'(2*i + 32)});
    end
    chk("b_overflow", 32'(overflow), 32'd0);
    chk("b_size", 32'(load_size), 32'd16);

    // Overflow: stream 40 bytes ignoring ioctl_wait with no acks
    ack_en = 1'b0; wb = wr_cnt; db = done_cnt;
    start_dl(8'(IDX));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i);
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    chk("o_overflow", 32'(overflow), 32'd1);
    ack_en = 1'b1; ioctl_download = 1'b0;
    wait_done(db, "o_done");
    chk("o_wr_cnt", 32'(wr_cnt - wb), 32'd9);
    chk("o_last_addr", {8'd0, log_addr[wb+8]}, 32'h8);
    chk("o_last_data", 32'(log_din[wb+8]), 32'h1110);
    chk("o_sticky", 32'(overflow), 32'd1);

    // Range error: out-of-range byte dropped, in-range byte kept
    wb = wr_cnt; db = done_cnt;
    start_dl(8'(IDX));
    chk("r_ovf_cleared", 32'(overflow), 32'd0);
    send_byte(25'h1000000, 8'h55);
    send_byte(25'h10, 8'h77);
    ioctl_download = 1'b0;
    wait_done(db, "r_done");
    chk("r_range_err", 32'(range_err), 32'd1);
    chk("r_wr_cnt", 32'(wr_cnt - wb), 32'd1);
    chk("r_w0", {8'd0, log_addr[wb]}, 32'h8);
    chk("r_d0", {14'd0, log_be[wb], log_din[wb]}, 32'h10077);
    chk("r_size", 32'(load_size), 32'h11);

    // Foreign index: ignored entirely
    wb = wr_cnt; db = done_cnt;
    start_dl(8'(IDX + 1));
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(i + 1));
    ioctl_download = 1'b0;
    repeat (20) @(negedge clk_sys);
    chk("i_no_write", 32'(wr_cnt - wb), 32'd0);
    chk("i_no_done", 32'(done_cnt - db), 32'd0);
    chk("i_range_kept", 32'(range_err), 32'd1);

    // Reset in the middle of a load with a request outstanding
    ack_en = 1'b0; wb = wr_cnt; db = done_cnt;
    start_dl(8'(IDX));
    chk("x_range_cleared", 32'(range_err), 32'd0);
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(i + 1));
    chk("x_req_pending", 32'(mem_req), 32'd1);
    @(negedge clk_sys);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("x_req_async_drop", 32'(mem_req), 32'd0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    ack_en = 1'b1;
    repeat (20) @(negedge clk_sys);
    chk("x_no_done", 32'(done_cnt - db), 32'd0);
    chk("x_no_write", 32'(wr_cnt - wb), 32'd0);
    chk("x_req_idle", 32'(mem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ioctl_sdram_loader.md
Name: ioctl_sdram_loader

Overview:
- Sits directly downstream of the HPS I/O block's file-download port (ioctl_*) and feeds a 16-bit word-addressed memory controller (SDRAM/DDR arbiter port).
- Packs the byte stream into 16-bit words with byte enables and buffers them in a small FIFO.
- Throttles the HPS through ioctl_wait.
- Reports completion, loaded size and error flags to the core.

Parameters:
- INDEX, 0, ioctl_index value this loader accepts; downloads with any other index are ignored entirely.
- FIFO_BITS, 3, log2 of FIFO depth (depth 8 entries).
- MEM_AW, 22, memory word-address width; byte capacity = 2^(MEM_AW+1).

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download active level.
- ioctl_index  in  8  menu index of current download.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address of ioctl_dout.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  stall request to the HPS.
- mem_req  out  1  write request, level.
- mem_addr  out  MEM_AW  word address.
- mem_din  out  16  write data, byte at even address in [7:0].
- mem_be  out  2  byte enables, [0]=low byte.
- mem_ack  in  1  one-cycle acceptance pulse.
- load_done  out  1  one-cycle pulse when all data of an accepted download is written.
- load_size  out  25  highest accepted ioctl_addr+1; valid from load_done until next start.
- overflow  out  1  sticky: a byte was lost due to FIFO full.
- range_err  out  1  sticky: a byte had ioctl_addr[24:MEM_AW+1] != 0 and was dropped.

Behaviour:
- Clock/reset: one clock (clk_sys); reset is asynchronous and active-low (reset_n).
- Reset values:
  - All outputs 0.
  - FIFO empty, hold register invalid, state IDLE.
  - Reset mid-transfer abandons the FIFO contents and any outstanding mem_req without completion.
- Active: active = ioctl_download && (ioctl_index == INDEX). Bytes with ioctl_wr while not active are ignored.
- States:
  - IDLE: on rising edge of active, clear overflow, range_err, load_size and the hold register, then go to LOAD. Entries still in the FIFO from a prior load continue draining.
  - LOAD: accept bytes. On falling edge of active, go to FLUSH.
  - FLUSH: push the hold register if valid, then wait until the FIFO is empty and mem_req=0, then go to DONE.
  - DONE: load_done=1 for exactly one cycle, then IDLE.
- Packing (at most one FIFO push per cycle):
  - Hold register = {word address, byte, which half}.
  - Byte arrives, hold invalid: store in hold.
  - Byte arrives for the same word and the opposite half as hold: push the combined word with be=2'b11; hold becomes invalid.
  - Byte arrives for a different word, or the same half: push hold alone (be=01 for even, 10 for odd; unused data bits 0); the new byte goes to hold.
  - load_size <= max(load_size, ioctl_addr+1) for every accepted byte.
- Push while the FIFO is full: entry dropped, overflow set. The hold register still updates as if the push succeeded.
- ioctl_wait: registered; 1 when FIFO occupancy >= depth-2, or state is FLUSH. Two slots of slack absorb wr strobes already in flight.
- Memory side:
  - When mem_req=0 and the FIFO is non-empty: pop the head into mem_addr/mem_din/mem_be and set mem_req=1 in the same edge.
  - mem_addr/mem_din/mem_be stay stable while mem_req=1.
  - mem_ack with mem_req=1 clears mem_req next edge. mem_ack while mem_req=0 is ignored.
  - Minimum one idle cycle between requests; peak throughput one word per 2 cycles.
- Simultaneous push and pop in one cycle are both honoured; occupancy is unchanged. Pointers wrap modulo depth.
- Latency: byte completing a word → mem_req high 2 cycles later, when the FIFO was empty and mem_req=0.

Test Plan:
- Contiguous load: INDEX match, 6 bytes 11..16 at addr 0..5, mem_ack 1 cycle after each req → three writes: addr0 din 0x1211, addr1 0x1413, addr2 0x1615, all be=11. Then load_done pulse, load_size=6, no error flags.
- Odd-length tail: 3 bytes AA,BB,CC at addr 0..2, then download drops → second write addr1 din 0x00CC be=01 occurs in FLUSH before load_done.
- Backpressure: mem_ack withheld for 40 cycles, bytes streamed every cycle while honouring ioctl_wait → ioctl_wait rises at occupancy 6. No overflow; all words written in order after ack resumes.
- Overflow and range errors:
  - Ignore ioctl_wait and stream 40 bytes with mem_ack held low → overflow=1.
  - Byte at addr 0x1000000 with MEM_AW=22 → range_err=1, no mem write for it.
  - Both flags clear on the next download start.
- Index filter and reset: a download with ioctl_index=INDEX+1 produces no mem_req and no load_done. Asserting reset_n=0 mid-load with mem_req=1 → mem_req drops immediately, and no load_done follows.
